reg_pipe_elastic: RTL and testbench
===================================

Name: reg_pipe_elastic

Overview:
- Parametrised multi-stage register pipeline that generalises the single D flip-flop to WIDTH bits and DEPTH stages.
- Each stage carries a per-stage valid bit, so the pipeline supports valid/ready backpressure.
- Bubbles collapse: an empty stage always accepts from upstream, even when the output is stalled.
- Provides a synchronous flush in addition to the asynchronous reset, plus a registered occupancy count.
- Used wherever the datapath needs retiming stages that must tolerate downstream stalls.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of register stages (>=1).
- RESET_VAL, 0, value loaded into every data register on rst, and on clr when CLR_DATA=1.
- CLR_DATA, 1, 1: clr also forces data registers to RESET_VAL; 0: clr clears valid bits only.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- clr, input, 1, synchronous flush, active-high.
- in_valid, input, 1, upstream beat present.
- in_data, input, WIDTH, upstream data.
- in_ready, output, 1, pipeline can accept a beat this cycle.
- out_valid, output, 1, last stage holds a beat.
- out_data, output, WIDTH, last-stage data.
- out_ready, input, 1, downstream accepts this cycle.
- count, output, $clog2(DEPTH+1), number of valid stages (registered).

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- rst asserted: immediately, without waiting for a clock edge, all stage valid bits = 0, all data registers = RESET_VAL, count = 0. As a result out_valid = 0, out_data = RESET_VAL and in_ready = 1 (combinational from the cleared valids).
- Deassertion of rst takes effect at the next rising edge.
- Stage i = 0..DEPTH-1; stage DEPTH-1 drives out_*.
- adv[DEPTH-1] = !v[DEPTH-1] || out_ready.
- adv[i] = !v[i] || adv[i+1], for i < DEPTH-1.
- in_ready = adv[0]. This is combinational; there is no combinational path from in_valid to in_ready.
- On each rising edge with clr=0:
  - If adv[0]: v[0] <= in_valid; d[0] <= in_data when in_valid, otherwise d[0] holds.
  - For i > 0, if adv[i]: v[i] <= v[i-1]; d[i] <= d[i-1] when v[i-1].
  - A stage with adv[i]=0 holds its valid bit and data.
- Latency: a beat accepted at edge E into an empty pipeline with out_ready=1 appears on out_valid/out_data after edge E+DEPTH-1.
- Throughput: 1 beat per cycle when out_ready is held high.
- Ordering: beats are never reordered, duplicated or dropped unless clr is asserted.
- Bubble collapse: while out_ready=0, in_ready stays 1 until all DEPTH stages are valid. Maximum occupancy is DEPTH.
- Full and stalled (all v=1, out_ready=0): in_ready = 0 and every stage holds.
- Full with out_ready=1: in_ready = 1. A simultaneous input and output transfer leaves count unchanged.
- count update:
  - in_valid&&in_ready and !(out_valid&&out_ready): count+1.
  - The reverse case: count-1.
  - Both or neither: count unchanged.
  - Invariant: count never exceeds DEPTH and never underflows.
- clr at a rising edge takes priority over all transfers:
  - All v <= 0 and count <= 0.
  - Data <= RESET_VAL if CLR_DATA=1, otherwise data holds.
  - A beat offered on the input in that same cycle is discarded, even though in_ready may read 1.
  - Any out_valid&&out_ready handshake in that cycle is still a completed transfer downstream; the pipeline state is cleared regardless.
- rst mid-operation: all in-flight beats are lost and the pipeline behaves as freshly reset.
- DEPTH=1: single registered stage with ready passthrough (in_ready = !v[0] || out_ready).

Test Plan:
- Reset: assert rst mid-cycle while 3 beats are in flight (DEPTH=4) -> out_valid=0, count=0 and out_data=RESET_VAL immediately, before the next clk edge; in_ready=1.
- Streaming: out_ready=1; drive beats 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles -> 0x11 first valid after edge E+3; outputs in order, one per cycle; count stays 4 in steady state.
- Backpressure/bubble collapse: out_ready=0; send 0xA1 then idle 2 cycles then 0xA2, 0xA3, 0xA4 -> in_ready stays 1 until count=4, then 0; raise out_ready -> outputs A1, A2, A3, A4 with no gaps, in_ready=1 in the same cycle.
- Full with simultaneous in/out: pipeline full, out_ready=1, in_valid=1 with 0xB0 -> in_ready=1, count stays 4, 0xB0 emerges 4 transfers later.
- Flush: 3 beats resident, assert clr for 1 cycle with in_valid=1 carrying 0xCC -> next cycle count=0, out_valid=0, 0xCC never appears; with CLR_DATA=1 out_data=RESET_VAL, with CLR_DATA=0 out_data unchanged.
- DEPTH=1, WIDTH=16: alternating out_ready 1/0 with continuous input -> no loss, no duplication, order preserved; scoreboard matches.

Source files
------------

// File: rtl/reg_pipe_elastic.sv
// rtl/reg_pipe_elastic.sv - elastic WIDTH x DEPTH register pipeline with valid/ready and bubble collapse
module reg_pipe_elastic #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit              CLR_DATA  = 1'b1,
  localparam int             CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]               count_q, count_d;
  logic [DEPTH-1:0]            adv;
  logic                        push, pop;

  // Advance chain from the output backwards: a stage may move when it is empty
  // or when the stage after it is moving, so empty stages always absorb bubbles.
  always_comb begin : adv_chain
    logic carry;
    adv          = '0;
    carry        = !valid_q[DEPTH-1] || out_ready;
    adv[DEPTH-1] = carry;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      carry  = !valid_q[i] || carry;
      adv[i] = carry;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_q;
  assign push      = in_valid && adv[0];
  assign pop       = valid_q[DEPTH-1] && out_ready;

  // Next state: flush wins over every transfer; otherwise each advancing stage
  // takes its upstream neighbour, loading data only when that neighbour is valid.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (clr) begin
      valid_d = '0;
      count_d = '0;
      if (CLR_DATA) begin
        data_d = {DEPTH{RESET_VAL}};
      end
    end else begin
      if (adv[0]) begin
        valid_d[0] = in_valid;
        if (in_valid) begin
          data_d[0] = in_data;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          valid_d[i] = valid_q[i-1];
          if (valid_q[i-1]) begin
            data_d[i] = data_q[i-1];
          end
        end
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (!push && pop) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // State registers; reset clears everything immediately, without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= {DEPTH{RESET_VAL}};
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_reg_pipe_elastic.sv
// tb/tb_reg_pipe_elastic.sv - self-checking bench for reg_pipe_elastic
module tb_reg_pipe_elastic;

  typedef struct {
    logic       clr;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [2:0] e_cnt;
    logic       chk;
    logic [7:0] e_da;
    logic [7:0] e_db;
  } vec_t;

  logic        clk, rst, clr, iv, ordy;
  logic [7:0]  idata;
  logic        a_ir, a_ov, b_ir, b_ov;
  logic [7:0]  a_od, b_od;
  logic [2:0]  a_cnt, b_cnt;
  logic        d1_clr, d1_iv, d1_or, d1_ir, d1_ov;
  logic [15:0] d1_data, d1_od;
  logic [0:0]  d1_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[$];
  logic [7:0]  sb[$];
  logic [15:0] q1[$];

  reg_pipe_elastic #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A), .CLR_DATA(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(iv), .in_data(idata), .in_ready(a_ir),
    .out_valid(a_ov), .out_data(a_od), .out_ready(ordy), .count(a_cnt));

  reg_pipe_elastic #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A), .CLR_DATA(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(iv), .in_data(idata), .in_ready(b_ir),
    .out_valid(b_ov), .out_data(b_od), .out_ready(ordy), .count(b_cnt));

  reg_pipe_elastic #(.WIDTH(16), .DEPTH(1), .RESET_VAL(16'h0000), .CLR_DATA(1'b1)) u_dut_d1 (
    .clk(clk), .rst(rst), .clr(d1_clr), .in_valid(d1_iv), .in_data(d1_data), .in_ready(d1_ir),
    .out_valid(d1_ov), .out_data(d1_od), .out_ready(d1_or), .count(d1_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  function automatic vec_t mk(input int c, input int v, input int d, input int o,
                              input int ir, input int ov, input int cnt);
    vec_t r;
    r.clr = c[0]; r.iv = v[0]; r.d = d[7:0]; r.ordy = o[0];
    r.e_ir = ir[0]; r.e_ov = ov[0]; r.e_cnt = cnt[2:0];
    r.chk = 1'b0; r.e_da = 8'h00; r.e_db = 8'h00;
    return r;
  endfunction

  initial begin
    vec_t t;
    logic [7:0]  want8;
    logic [15:0] nxt;
    int o1;
    logic exp_ir, push_m, pop_m;

    rst = 1'b1; clr = 1'b0; iv = 1'b0; idata = 8'h00; ordy = 1'b0;
    d1_clr = 1'b0; d1_iv = 1'b0; d1_data = 16'h0000; d1_or = 1'b0;

    // streaming, out_ready high: clr, iv, data, ordy, exp in_ready, exp out_valid, exp count
    tbl.push_back(mk(0,1,'h11,1, 1,0,0));
    tbl.push_back(mk(0,1,'h22,1, 1,0,1));
    tbl.push_back(mk(0,1,'h33,1, 1,0,2));
    tbl.push_back(mk(0,1,'h44,1, 1,0,3));
    tbl.push_back(mk(0,1,'h55,1, 1,1,4));
    tbl.push_back(mk(0,0,'h00,1, 1,1,4));
    tbl.push_back(mk(0,0,'h00,1, 1,1,3));
    tbl.push_back(mk(0,0,'h00,1, 1,1,2));
    tbl.push_back(mk(0,0,'h00,1, 1,1,1));
    tbl.push_back(mk(0,0,'h00,1, 1,0,0));
    // backpressure with bubbles, then release
    tbl.push_back(mk(0,1,'hA1,0, 1,0,0));
    tbl.push_back(mk(0,0,'h00,0, 1,0,1));
    tbl.push_back(mk(0,0,'h00,0, 1,0,1));
    tbl.push_back(mk(0,1,'hA2,0, 1,0,1));
    tbl.push_back(mk(0,1,'hA3,0, 1,1,2));
    tbl.push_back(mk(0,1,'hA4,0, 1,1,3));
    tbl.push_back(mk(0,1,'hA5,0, 0,1,4));
    tbl.push_back(mk(0,1,'hA5,1, 1,1,4));
    tbl.push_back(mk(0,0,'h00,1, 1,1,4));
    tbl.push_back(mk(0,0,'h00,1, 1,1,3));
    tbl.push_back(mk(0,0,'h00,1, 1,1,2));
    tbl.push_back(mk(0,0,'h00,1, 1,1,1));
    tbl.push_back(mk(0,0,'h00,1, 1,0,0));
    // full with simultaneous input and output
    tbl.push_back(mk(0,1,'hB1,0, 1,0,0));
    tbl.push_back(mk(0,1,'hB2,0, 1,0,1));
    tbl.push_back(mk(0,1,'hB3,0, 1,0,2));
    tbl.push_back(mk(0,1,'hB4,0, 1,0,3));
    tbl.push_back(mk(0,1,'hB0,1, 1,1,4));
    tbl.push_back(mk(0,0,'h00,1, 1,1,4));
    tbl.push_back(mk(0,0,'h00,1, 1,1,3));
    tbl.push_back(mk(0,0,'h00,1, 1,1,2));
    tbl.push_back(mk(0,0,'h00,1, 1,1,1));
    tbl.push_back(mk(0,0,'h00,1, 1,0,0));
    // flush with a beat offered in the same cycle
    tbl.push_back(mk(0,1,'hC1,0, 1,0,0));
    tbl.push_back(mk(0,1,'hC2,0, 1,0,1));
    tbl.push_back(mk(0,1,'hC3,0, 1,0,2));
    tbl.push_back(mk(0,0,'h00,0, 1,0,3));
    tbl.push_back(mk(1,1,'hCC,0, 1,1,3));
    t = mk(0,0,'h00,1, 1,0,0); t.chk = 1'b1; t.e_da = 8'h5A; t.e_db = 8'hC1;
    tbl.push_back(t);
    tbl.push_back(mk(0,0,'h00,1, 1,0,0));
    tbl.push_back(mk(0,0,'h00,1, 1,0,0));

    #2;
    check("reset out_valid", {31'd0, a_ov}, 0);
    check("reset count", {29'd0, a_cnt}, 0);
    check("reset out_data", {24'd0, a_od}, 'h5A);
    check("reset in_ready", {31'd0, a_ir}, 1);
    check("reset d1 out_valid", {31'd0, d1_ov}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      clr = tbl[i].clr; iv = tbl[i].iv; idata = tbl[i].d; ordy = tbl[i].ordy;
      @(negedge clk);
      check($sformatf("v%0d a in_ready", i), {31'd0, a_ir}, {31'd0, tbl[i].e_ir});
      check($sformatf("v%0d a out_valid", i), {31'd0, a_ov}, {31'd0, tbl[i].e_ov});
      check($sformatf("v%0d a count", i), {29'd0, a_cnt}, {29'd0, tbl[i].e_cnt});
      check($sformatf("v%0d b in_ready", i), {31'd0, b_ir}, {31'd0, tbl[i].e_ir});
      check($sformatf("v%0d b out_valid", i), {31'd0, b_ov}, {31'd0, tbl[i].e_ov});
      check($sformatf("v%0d b count", i), {29'd0, b_cnt}, {29'd0, tbl[i].e_cnt});
      if (a_ov && tbl[i].ordy) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL v%0d unexpected beat: got %0h, expected none", i, a_od);
        end else begin
          want8 = sb.pop_front();
          check($sformatf("v%0d a out_data", i), {24'd0, a_od}, {24'd0, want8});
          check($sformatf("v%0d b out_data", i), {24'd0, b_od}, {24'd0, want8});
        end
      end
      if (tbl[i].chk) begin
        check($sformatf("v%0d a flushed data", i), {24'd0, a_od}, {24'd0, tbl[i].e_da});
        check($sformatf("v%0d b held data", i), {24'd0, b_od}, {24'd0, tbl[i].e_db});
      end
      if (tbl[i].clr) sb.delete();
      if (tbl[i].iv && tbl[i].e_ir && !tbl[i].clr) sb.push_back(tbl[i].d);
      @(posedge clk); #1;
    end
    clr = 1'b0;
    check("main scoreboard drained", sb.size(), 0);

    // asynchronous reset with three beats in flight
    ordy = 1'b0; iv = 1'b1; idata = 8'hD1;
    @(posedge clk); #1; idata = 8'hD2;
    @(posedge clk); #1; idata = 8'hD3;
    @(posedge clk); #1; iv = 1'b0;
    @(posedge clk); #1;
    check("pre-rst out_valid", {31'd0, a_ov}, 1);
    check("pre-rst count", {29'd0, a_cnt}, 3);
    check("pre-rst out_data", {24'd0, a_od}, 'hD1);
    #2; rst = 1'b1; #1;
    check("async rst out_valid", {31'd0, a_ov}, 0);
    check("async rst count", {29'd0, a_cnt}, 0);
    check("async rst out_data", {24'd0, a_od}, 'h5A);
    check("async rst in_ready", {31'd0, a_ir}, 1);
    check("async rst b out_valid", {31'd0, b_ov}, 0);
    @(posedge clk); #1;
    rst = 1'b0; iv = 1'b1; idata = 8'hE1; ordy = 1'b1;
    @(posedge clk); #1; iv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("post-rst latency k%0d out_valid", k), {31'd0, a_ov}, (k == 3) ? 1 : 0);
      if (k == 3) check("post-rst out_data", {24'd0, a_od}, 'hE1);
      @(posedge clk); #1;
    end
    ordy = 1'b0;

    // DEPTH=1: continuous input, alternating out_ready
    nxt = 16'h1000; o1 = 0;
    for (int k = 0; k < 28; k++) begin
      d1_iv = (k < 24); d1_data = nxt; d1_or = (k % 2 == 0);
      @(negedge clk);
      exp_ir = (o1 == 0) || d1_or;
      check($sformatf("d1 k%0d in_ready", k), {31'd0, d1_ir}, {31'd0, exp_ir});
      check($sformatf("d1 k%0d out_valid", k), {31'd0, d1_ov}, o1);
      check($sformatf("d1 k%0d count", k), {31'd0, d1_cnt}, o1);
      if (d1_ov && d1_or) begin
        if (q1.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL d1 k%0d unexpected beat: got %0h, expected none", k, d1_od);
        end else begin
          check($sformatf("d1 k%0d out_data", k), {16'd0, d1_od}, {16'd0, q1.pop_front()});
        end
      end
      pop_m  = (o1 == 1) && d1_or;
      push_m = d1_iv && exp_ir;
      if (push_m) begin
        q1.push_back(nxt);
        nxt = nxt + 16'h0001;
      end
      o1 = push_m ? 1 : (pop_m ? 0 : o1);
      @(posedge clk); #1;
    end
    check("d1 scoreboard drained", q1.size(), 0);
    check("d1 beats sent", {16'd0, nxt}, 'h100C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
